// File: rtl/aes_pkg.sv
// Shared AES constants, state enum and GF(2^8) helpers for the round datapath blocks.
// Pure declarations: no latency, no flow control.
package aes_pkg;

  localparam int unsigned AES_WIDTH = 128;
  localparam int unsigned AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in and one byte out, used by SubWord and SubBytes.
// Purely combinational: no latency, no flow control.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n) = {~n, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key (0..NR) per valid/ready handshake, first key one cycle after start.
// Holds all state while ready_i is low; done_o pulses the cycle after round NR is accepted.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = AES_WIDTH,
  parameter int unsigned NR    = AES_NR
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] key_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [3:0]       round_o,
  output logic [WIDTH-1:0] rkey_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [3:0] LAST = 4'(NR);

  aes_state_e       state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [3:0]       round_q, round_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             done_q, done_d;

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      rot, sub, t;
  logic [31:0]      n0, n1, n2, n3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .y (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d   = key_i;
          round_d = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ready_i) begin
          if (round_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = {n0, n1, n2, n3};
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = (state_q == RUN);
  assign busy_o  = (state_q == RUN);
  assign round_o = round_q;
  assign rkey_o  = key_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand against FIPS-197 key-schedule vectors.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         ready;
  logic         valid;
  logic [3:0]   round;
  logic [127:0] rkey;
  logic         busy;
  logic         done;

  int tests;
  int fails;

  logic [127:0] fips_rk [11];
  logic [127:0] key_b;
  logic [127:0] key_b_r10;

  aes_key_expand #(.WIDTH(128), .NR(10)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .key_i   (key),
    .ready_i (ready),
    .valid_o (valid),
    .round_o (round),
    .rkey_o  (rkey),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready = 1'b0; key = '0;
    tick; tick;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (round !== 4'd0) begin fails++; $display("FAIL reset_round got=%0d exp=0", round); end
    tests++; if (rkey !== 128'h0) begin fails++; $display("FAIL reset_rkey got=%h exp=0", rkey); end
    rst = 1'b0;
    tick;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got=%b exp=0", valid); end
  endtask

  task automatic test_idle_quiet;
    for (int i = 0; i < 8; i++) begin
      ready = i[0];
      tick;
      tests++;
      if ({valid, done, busy} !== 3'b000) begin
        fails++; $display("FAIL idle_quiet cyc=%0d got v/d/b=%b exp=000", i, {valid, done, busy});
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_fips;
    ready = 1'b1; key = fips_rk[0]; start = 1'b1;
    tick;
    start = 1'b0; key = '0;
    for (int r = 0; r <= 10; r++) begin
      tests++;
      if (valid !== 1'b1 || done !== 1'b0 || round !== 4'(r) || rkey !== fips_rk[r]) begin
        fails++;
        $display("FAIL fips_round%0d got v=%b d=%b rnd=%0d key=%h exp v=1 d=0 rnd=%0d key=%h",
                 r, valid, done, round, rkey, r, fips_rk[r]);
      end
      tick;
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL fips_done got=%b exp=1", done); end
    tests++; if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL fips_idle_after got v=%b b=%b exp v=0 b=0", valid, busy);
    end
    tick;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL fips_done_width got=%b exp=0", done); end
  endtask

  task automatic test_backpressure;
    ready = 1'b1; key = fips_rk[0]; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    tests++; if (round !== 4'd4) begin fails++; $display("FAIL bp_reach4 got=%0d exp=4", round); end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if (valid !== 1'b1 || round !== 4'd4 || rkey !== fips_rk[4]) begin
        fails++;
        $display("FAIL bp_hold%0d got v=%b rnd=%0d key=%h exp v=1 rnd=4 key=%h", i, valid, round, rkey, fips_rk[4]);
      end
    end
    ready = 1'b1;
    tick;
    tests++;
    if (round !== 4'd5 || rkey !== fips_rk[5]) begin
      fails++; $display("FAIL bp_resume got rnd=%0d key=%h exp rnd=5 key=%h", round, rkey, fips_rk[5]);
    end
    repeat (6) tick;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done got=%b exp=1", done); end
    tick;
  endtask

  task automatic test_reset_mid;
    ready = 1'b1; key = fips_rk[0]; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    tests++; if (round !== 4'd6) begin fails++; $display("FAIL rm_reach6 got=%0d exp=6", round); end
    rst = 1'b1;
    #1;
    tests++;
    if ({valid, busy, done} !== 3'b000 || round !== 4'd0 || rkey !== 128'h0) begin
      fails++; $display("FAIL rm_async got v/b/d=%b rnd=%0d key=%h exp 000 0 0", {valid, busy, done}, round, rkey);
    end
    tick;
    rst = 1'b0;
    tick; tick;
    tests++; if (valid !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rm_quiet got v=%b d=%b exp v=0 d=0", valid, done);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++; if (round !== 4'd0 || rkey !== fips_rk[0]) begin
      fails++; $display("FAIL rm_restart_r0 got rnd=%0d key=%h exp rnd=0 key=%h", round, rkey, fips_rk[0]);
    end
    tick;
    tests++; if (round !== 4'd1 || rkey !== fips_rk[1]) begin
      fails++; $display("FAIL rm_restart_r1 got rnd=%0d key=%h exp rnd=1 key=%h", round, rkey, fips_rk[1]);
    end
    repeat (10) tick;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL rm_done got=%b exp=1", done); end
    tick;
  endtask

  // Leaves the bench in the done_o cycle so the back-to-back start follows directly.
  task automatic test_start_busy;
    ready = 1'b1; key = fips_rk[0]; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    start = 1'b1; key = key_b;
    tick;
    start = 1'b0;
    for (int r = 4; r <= 10; r++) begin
      tests++;
      if (valid !== 1'b1 || round !== 4'(r) || rkey !== fips_rk[r]) begin
        fails++;
        $display("FAIL sb_round%0d got v=%b rnd=%0d key=%h exp v=1 rnd=%0d key=%h", r, valid, round, rkey, r, fips_rk[r]);
      end
      tick;
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL sb_done got=%b exp=1", done); end
  endtask

  task automatic test_back_to_back;
    key = key_b; start = 1'b1;
    tick;
    start = 1'b0;
    tests++; if (valid !== 1'b1 || round !== 4'd0 || rkey !== key_b) begin
      fails++; $display("FAIL b2b_r0 got v=%b rnd=%0d key=%h exp v=1 rnd=0 key=%h", valid, round, rkey, key_b);
    end
    repeat (10) tick;
    tests++; if (round !== 4'd10 || rkey !== key_b_r10) begin
      fails++; $display("FAIL b2b_r10 got rnd=%0d key=%h exp rnd=10 key=%h", round, rkey, key_b_r10);
    end
    tick;
    tests++; if (done !== 1'b1 || valid !== 1'b0) begin
      fails++; $display("FAIL b2b_done got d=%b v=%b exp d=1 v=0", done, valid);
    end
    tick;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_b       = 128'h000102030405060708090a0b0c0d0e0f;
    key_b_r10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    test_reset;
    test_idle_quiet;
    test_fips;
    test_backpressure;
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
    test_idle_quiet;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES-128 key schedule that turns the 128-bit cipher key into the eleven round keys (round 0..10) consumed by the AddRoundKey stage directly downstream of MixColumn. It produces one round key per handshake on a valid/ready interface, so the round datapath can pull keys in step with its own iterations. It computes one key per cycle and stores no key table.

## Interface
Parameters:
- WIDTH, 128, state/key width. Fixed at 128; any other value is unsupported.
- NR, 10, number of rounds. Sets the last round index.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request to begin expansion. Sampled only in IDLE.
- key_i  in  WIDTH  cipher key. Word w0 = key_i[127:96], w3 = key_i[31:0]. Captured on the accepted start_i.
- ready_i  in  1  consumer accepts rkey_o this cycle.
- valid_o  out  1  rkey_o/round_o hold a valid round key.
- round_o  out  4  index of the current round key, 0..NR.
- rkey_o  out  WIDTH  current round key, with the same word order as key_i.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse after round NR is accepted.

## Operation
- States: IDLE and RUN.
- IDLE, start_i=1: register key_i into the key register, clear round to 0, load rcon with 8'h01, and go to RUN.
- RUN: valid_o=1 and rkey_o = key register.
- RUN, valid_o && ready_i && round_o<NR: the key register takes the next key, round increments, and rcon becomes xtime(rcon).
- RUN, valid_o && ready_i && round_o==NR: go to IDLE and set done_o for the next cycle.
- RUN, ready_i=0: all outputs and registers hold.
- Next-key rule, with the current key = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES S-box to each byte.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - All byte arithmetic is 8-bit GF(2^8). There are no carries.
- start_i in RUN is ignored; key_i changes in RUN have no effect.
- Reset values: valid_o=0, busy_o=0, done_o=0, round_o=0, rkey_o=0. The rcon register resets to 8'h01 and the state to IDLE.
- Reset asserted mid-RUN aborts at once. There is no partial done_o and no further valid_o until a new start.

## Timing
- Start latency: start_i accepted at edge T gives valid_o=1 with round_o=0 from T+1.
- Throughput: one key per cycle with no bubbles. Next-key logic is combinational from the key register into the register. The new key appears the cycle after each handshake edge.
- With ready_i held high, valid_o stays high for exactly NR+1=11 cycles. done_o is high in cycle 12 relative to the first valid cycle.
- done_o cycle: the block is already in IDLE. start_i=1 in that cycle is accepted, and valid_o rises the following cycle.
- The valid_o→ready_i handshake completes only when both are high at a rising edge. valid_o never drops without a handshake, except on reset.
- Critical path: S-box lookup, then XOR chain through w3'. No pipelining is required at the target clock.

## Structure
- Shared package aes_pkg holds the following, shared with MixColumn/AddRoundKey:
  - AES_WIDTH=128 and AES_NR=10.
  - RCON_INIT=8'h01.
  - The xtime function.
  - The state enum (IDLE, RUN).
- One sub-module, aes_sbox: a combinational 8-bit in, 8-bit out, 256-entry lookup, instantiated four times for SubWord. The same module serves SubBytes.
- The remainder is one always block for state/registers and combinational next-key logic.

## Test plan
- FIPS-197 vector, ready_i=1:
  - Stimulus: key_i=2b7e151628aed2a6abf7158809cf4f3c and start pulse.
  - round_o=0 gives rkey_o=key_i.
  - round 1 gives a0fafe1788542cb123a339392a6c7605.
  - round 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done_o pulses once, 11 cycles after valid_o rises.
- Backpressure: same key with ready_i low for 3 cycles while round_o=4 → rkey_o and round_o hold stable. The sequence resumes with the correct round 5 key.
- Reset mid-run: assert rst_i while round_o=6 → all outputs 0 immediately. A new start gives round 0 = key_i, and rcon restarts at 01; round 1 is checked against the vector.
- Start while busy: pulse start_i with a different key_i at round 3 → ignored, and the original schedule completes unchanged.
- Back-to-back: start_i=1 in the done_o cycle with key 000102030405060708090a0b0c0d0e0f → round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Idle quiet: ready_i toggling with no start → valid_o, done_o and busy_o stay 0.
